psk_symbol_tx: RTL
==================

# psk_symbol_tx

Transmit-side symbol generator for the BPSK/QPSK link. It accepts one symbol of bits per handshake and maps them to ±AMP I/Q levels. Each symbol is held for SPS samples, producing the 32-samples-per-symbol baseband stream that the receive chain's Gardner timing loop expects. It sits between the framing/bit source and the DAC/upconversion path; I and Q carry identical data in BPSK mode.

## Interface
- WIDTH, 16, signed sample width of I/Q
- SPS, 32, samples per symbol; power of two, ≥ 4
- AMP, 8192, positive symbol magnitude; must be < 2^(WIDTH-1)
- RAMP_LEN, 8, transition ramp length in samples; power of two, ≤ SPS/2; used only with PSK_TX_RAMP_EN

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- is_bpsk  in  1  1 = BPSK, 0 = QPSK; sampled only on an accepted handshake
- bit_data  in  2  symbol bits; QPSK uses [1] for I and [0] for Q; BPSK uses [0] only
- bit_valid  in  1  bit_data valid
- bit_ready  out  1  block can accept a symbol this cycle
- I  out  WIDTH  signed in-phase sample, registered
- Q  out  WIDTH  signed quadrature sample, registered
- sym_strobe  out  1  high for the first output sample of each symbol
- busy  out  1  high while in RUN

## Operation
- Mapping: bit 0 → +AMP, bit 1 → −AMP. The sign bit of the output therefore equals the transmitted bit.
- BPSK: I = Q = map(bit_data[0]).
- QPSK: I = map(bit_data[1]), Q = map(bit_data[0]).
- States: IDLE and RUN. Sample counter cnt runs 0..SPS−1 (log2(SPS) bits).
- IDLE:
  - I = Q = 0, cnt = 0, bit_ready = 1, busy = 0.
  - An accept (bit_valid & bit_ready) moves to RUN, loads the symbol and clears cnt.
- RUN:
  - cnt increments every cycle.
  - bit_ready = 1 only when cnt == SPS−1.
  - At cnt == SPS−1 with bit_valid: load the next symbol, wrap cnt to 0 and stay in RUN. This is gapless back-to-back operation.
  - At cnt == SPS−1 without bit_valid: go to IDLE; I/Q become 0 on the next cycle.
- bit_valid in any other RUN cycle is ignored. Upstream must hold bit_data and bit_valid until accepted.
- is_bpsk is latched with each accepted symbol. Changing it mid-symbol has no effect on the current symbol.
- A mode change between symbols takes effect at the next accepted symbol.

## Timing
- Reset values: I = 0, Q = 0, sym_strobe = 0, busy = 0, bit_ready = 1 (IDLE). cnt = 0, and the held previous level is 0.
- Latency: accept on edge N gives the new I/Q and sym_strobe = 1 in cycle N+1. sym_strobe is a single-cycle pulse.
- Each symbol occupies exactly SPS output cycles. The strobe period under continuous valid is exactly SPS.
- If rst is asserted mid-symbol, the block is in IDLE with reset values on the next cycle, and the symbol is dropped.
- rst takes priority over a same-cycle handshake; no accept occurs.
- bit_ready is combinational from state and cnt only, never from bit_valid.

## Configuration
- PSK_TX_RAMP_EN defined:
  - On each symbol load, I and Q ramp linearly from the previous level to the new level over RAMP_LEN samples.
  - step = (new − old) >>> log2(RAMP_LEN), computed at WIDTH+1 bits. The accumulator adds step each sample.
  - The sample at cnt == RAMP_LEN−1 is forced to exactly the new level.
  - The previous level is 0 when coming from IDLE.
  - With no polarity change, the output stays flat.
  - The transition to IDLE is not ramped; the output drops to 0 immediately.
- PSK_TX_RAMP_EN undefined: rectangular pulses. The new level appears in full on the strobe sample. RAMP_LEN is unused.

## Structure
- Shared package psk_pkg:
  - default WIDTH/SPS/AMP constants
  - state encoding for IDLE/RUN
  - the bit-to-level mapping function
- One natural sub-module: psk_symbol_mapper, a combinational block (is_bpsk, bit_data → I level, Q level). It is instantiated once, and its output is registered as the symbol target.

## Test plan
- Reset, then idle: after rst, I = Q = 0, bit_ready = 1, busy = 0 for 100 cycles with bit_valid = 0.
- QPSK single symbol: is_bpsk = 0, bit_data = 2'b01, one accept.
  - Required: I = +8192, Q = −8192 for exactly 32 cycles, strobe in the first of them.
  - Then I = Q = 0 and back to IDLE.
- BPSK stream, continuous valid, bits 0,1,1,0:
  - I = Q = +8192, −8192, −8192, +8192, each held 32 cycles with no gap.
  - Strobes are exactly 32 cycles apart.
  - bit_ready is high only in the last cycle of each symbol.
- Late valid: bit_valid rises at cnt = 10 of a symbol.
  - Required: no accept until cnt = 31.
  - The new symbol starts at the next symbol boundary.
- Reset mid-symbol: rst at cnt = 15 gives I = Q = 0 and IDLE the next cycle, and no strobe follows.
- PSK_TX_RAMP_EN, BPSK 0 then 1, RAMP_LEN = 8:
  - The second symbol's I steps 8192 − 2048·k for k = 1..7.
  - Sample 7 is exactly −8192.
  - The first symbol ramps from 0 in steps of 1024.

Source files
------------

// File: rtl/psk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psk_pkg
// Purpose  : Shared constants, FSM encoding and bit-to-level mapping for the
//            BPSK/QPSK symbol transmitter.
// Revision : 1.0
// ============================================================================
package psk_pkg;

   localparam int PSK_WIDTH    = 16;
   localparam int PSK_SPS      = 32;
   localparam int PSK_AMP      = 8192;
   localparam int PSK_RAMP_LEN = 8;

   typedef logic [0:0] psk_state_t;
   localparam psk_state_t ST_IDLE = 1'b0;
   localparam psk_state_t ST_RUN  = 1'b1;

   // A transmitted 1 is the negative level, so the sample sign bit equals the bit.
   function automatic int psk_level(input logic b, input int amp);
      return b ? -amp : amp;
   endfunction

endpackage
`default_nettype wire

// File: rtl/psk_symbol_mapper.sv
`default_nettype none
// ============================================================================
// Module   : psk_symbol_mapper
// Purpose  : Combinational mapping of symbol bits to signed I/Q target levels.
// Revision : 1.0
// ============================================================================
module psk_symbol_mapper
   import psk_pkg::*;
#(
   parameter int WIDTH = PSK_WIDTH,
   parameter int AMP   = PSK_AMP
) (
   input  logic                    is_bpsk,
   input  logic [1:0]              bit_data,
   output logic signed [WIDTH-1:0] lvl_i,
   output logic signed [WIDTH-1:0] lvl_q
);

   always_comb begin
      lvl_i = WIDTH'(psk_level(is_bpsk ? bit_data[0] : bit_data[1], AMP));
      lvl_q = WIDTH'(psk_level(bit_data[0], AMP));
   end

endmodule
`default_nettype wire

// File: rtl/psk_symbol_tx.sv
`default_nettype none
// ============================================================================
// Module   : psk_symbol_tx
// Purpose  : BPSK/QPSK symbol generator holding each symbol for SPS samples.
//            Define PSK_TX_RAMP_EN for linear level ramps on symbol loads.
// Revision : 1.0
// ============================================================================
module psk_symbol_tx
   import psk_pkg::*;
#(
   parameter int WIDTH    = PSK_WIDTH,
   parameter int SPS      = PSK_SPS,
   parameter int AMP      = PSK_AMP,
   parameter int RAMP_LEN = PSK_RAMP_LEN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    is_bpsk,
   input  logic [1:0]              bit_data,
   input  logic                    bit_valid,
   output logic                    bit_ready,
   output logic signed [WIDTH-1:0] I,
   output logic signed [WIDTH-1:0] Q,
   output logic                    sym_strobe,
   output logic                    busy
);

   localparam int              CNT_W    = $clog2(SPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

   if (SPS < 4 || (SPS & (SPS - 1)) != 0) begin : g_bad_sps
      $error("psk_symbol_tx: SPS must be a power of two and at least 4");
   end
   if (RAMP_LEN < 1 || RAMP_LEN > SPS / 2 || (RAMP_LEN & (RAMP_LEN - 1)) != 0) begin : g_bad_ramp
      $error("psk_symbol_tx: RAMP_LEN must be a power of two no larger than SPS/2");
   end
   if (AMP <= 0 || AMP >= (1 << (WIDTH - 1))) begin : g_bad_amp
      $error("psk_symbol_tx: AMP must be positive and below 2^(WIDTH-1)");
   end

   psk_state_t              state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_inc;
   logic                    at_last, accept;
   logic signed [WIDTH-1:0] map_i, map_q;

   assign cnt_inc = cnt + 1'b1;
   assign at_last = (cnt == CNT_LAST);
   assign accept  = bit_valid & bit_ready;

   psk_symbol_mapper #(
      .WIDTH (WIDTH),
      .AMP   (AMP)
   ) u_mapper (
      .is_bpsk  (is_bpsk),
      .bit_data (bit_data),
      .lvl_i    (map_i),
      .lvl_q    (map_q)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept)                  state_nxt = ST_RUN;
         ST_RUN:  if (at_last && !bit_valid)   state_nxt = ST_IDLE;
         default:                              state_nxt = ST_IDLE;
      endcase
   end

   // Ready depends only on state and count so upstream sees no valid->ready path.
   always_comb begin
      bit_ready = (state == ST_IDLE) || at_last;
      busy      = (state == ST_RUN);
   end

`ifdef PSK_TX_RAMP_EN
   localparam int               RAMP_SH   = $clog2(RAMP_LEN);
   localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_LEN - 1);

   logic signed [WIDTH-1:0] tgt_i, tgt_q, old_i, old_q;
   logic signed [WIDTH:0]   step_i, step_q, new_step_i, new_step_q;

   // A symbol only follows another one gaplessly; from IDLE the ramp starts at 0.
   assign old_i      = (state == ST_RUN) ? tgt_i : '0;
   assign old_q      = (state == ST_RUN) ? tgt_q : '0;
   assign new_step_i = ((WIDTH+1)'(map_i) - (WIDTH+1)'(old_i)) >>> RAMP_SH;
   assign new_step_q = ((WIDTH+1)'(map_q) - (WIDTH+1)'(old_q)) >>> RAMP_SH;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         I          <= '0;
         Q          <= '0;
         sym_strobe <= 1'b0;
         cnt        <= '0;
`ifdef PSK_TX_RAMP_EN
         tgt_i      <= '0;
         tgt_q      <= '0;
         step_i     <= '0;
         step_q     <= '0;
`endif
      end else begin
         sym_strobe <= accept;
         if (accept) begin
            cnt <= '0;
`ifdef PSK_TX_RAMP_EN
            tgt_i  <= map_i;
            tgt_q  <= map_q;
            step_i <= new_step_i;
            step_q <= new_step_q;
            I <= (RAMP_LAST == '0) ? map_i : WIDTH'((WIDTH+1)'(old_i) + new_step_i);
            Q <= (RAMP_LAST == '0) ? map_q : WIDTH'((WIDTH+1)'(old_q) + new_step_q);
`else
            I <= map_i;
            Q <= map_q;
`endif
         end else if (state == ST_RUN && !at_last) begin
            cnt <= cnt_inc;
`ifdef PSK_TX_RAMP_EN
            // The last ramp sample snaps to the target to absorb shift truncation.
            if (cnt_inc == RAMP_LAST) begin
               I <= tgt_i;
               Q <= tgt_q;
            end else if (cnt_inc < RAMP_LAST) begin
               I <= WIDTH'((WIDTH+1)'(I) + step_i);
               Q <= WIDTH'((WIDTH+1)'(Q) + step_q);
            end
`endif
         end else begin
            cnt <= '0;
            I   <= '0;
            Q   <= '0;
         end
      end
   end

endmodule
`default_nettype wire
